// File: rtl/dtc_pkg.sv
// dtc_pkg: shared types and default constants for the DTC link
// alignment sequencer.
//   state_t      - sequencer FSM states
//   *_DEF        - default parameter values for the sequencer
//   clog2_min1   - $clog2 that never returns less than 1, so that
//                  single-entry selects still get a 1-bit signal
package dtc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        ALIGN,
        WAIT,
        TEST,
        EVAL,
        NEXT,
        DONE
    } state_t;

    localparam logic [15:0] IDLE_WORD_DEF  = 16'hBC50;
    localparam int          NLINK_DEF      = 8;
    localparam int          ALIGN_WAIT_DEF = 4096;
    localparam int          TEST_LEN_DEF   = 1024;
    localparam int          ERR_THRESH_DEF = 0;
    localparam int          MAX_RETRY_DEF  = 3;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dtc_win_errchk.sv
// dtc_win_errchk: registered link-word mux plus windowed mismatch counter.
//   bitclkdiv   - word clock
//   reset       - synchronous, active-high
//   clear       - zero the mismatch count and the window position
//   enable      - perform one comparison this cycle
//   sel         - link whose word is registered for the next comparison
//   data        - all links' deserialized words, link i at [16i+15:16i]
//   count       - mismatches seen in the current window, saturating
//   window_done - high during the final comparison of the window
module dtc_win_errchk
    import dtc_pkg::*;
#(
    parameter int          NLINK     = NLINK_DEF,
    parameter int          TEST_LEN  = TEST_LEN_DEF,
    parameter logic [15:0] IDLE_WORD = IDLE_WORD_DEF
) (
    input  logic                           bitclkdiv,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           enable,
    input  logic [clog2_min1(NLINK)-1:0]   sel,
    input  logic [16*NLINK-1:0]            data,
    output logic [15:0]                    count,
    output logic                           window_done
);

    logic [15:0] word_q;
    logic [15:0] win_cnt;

    // The mux register loads every cycle, so the word captured during the
    // last wait cycle is already in place for the first comparison.
    always_ff @(posedge bitclkdiv) begin
        if (reset) begin
            word_q <= '0;
        end else begin
            word_q <= data[{sel, 4'b0000} +: 16];
        end
    end

    always_ff @(posedge bitclkdiv) begin
        if (reset || clear) begin
            count   <= '0;
            win_cnt <= '0;
        end else if (enable) begin
            win_cnt <= win_cnt + 16'd1;
            if ((word_q != IDLE_WORD) && (count != 16'hFFFF)) begin
                count <= count + 16'd1;
            end
        end
    end

    assign window_done = enable && (win_cnt == 16'(TEST_LEN - 1));

endmodule

// File: rtl/dtc_align_sched.sv
// dtc_align_sched: brings up the DTC receive links of one SRU one at a
// time: align pulse, settle wait, idle-word error window, retries.
//   bitclkdiv        - word clock
//   reset            - synchronous, active-high
//   start            - single-cycle request to sequence all unmasked links
//   link_mask        - 1 = skip link, captured when start is accepted
//   deser_dout       - deserialized words, link i at [16i+15:16i]
//   word_align_start - one-hot align pulse to the link being served
//   busy             - sequence in progress
//   done             - one-cycle pulse at the end of the sequence
//   link_ok          - link passed its error window
//   link_fail        - link exhausted its retries
//   cur_link         - link currently being served
//   last_errcnt      - mismatch count of the most recent window
module dtc_align_sched
    import dtc_pkg::*;
#(
    parameter int          NLINK      = NLINK_DEF,
    parameter logic [15:0] IDLE_WORD  = IDLE_WORD_DEF,
    parameter int          ALIGN_WAIT = ALIGN_WAIT_DEF,
    parameter int          TEST_LEN   = TEST_LEN_DEF,
    parameter int          ERR_THRESH = ERR_THRESH_DEF,
    parameter int          MAX_RETRY  = MAX_RETRY_DEF
) (
    input  logic                           bitclkdiv,
    input  logic                           reset,
    input  logic                           start,
    input  logic [NLINK-1:0]               link_mask,
    input  logic [16*NLINK-1:0]            deser_dout,
    output logic [NLINK-1:0]               word_align_start,
    output logic                           busy,
    output logic                           done,
    output logic [NLINK-1:0]               link_ok,
    output logic [NLINK-1:0]               link_fail,
    output logic [clog2_min1(NLINK)-1:0]   cur_link,
    output logic [15:0]                    last_errcnt
);

    localparam int SW = clog2_min1(NLINK);
    localparam int RW = clog2_min1(MAX_RETRY + 1);

    state_t          state;
    state_t          state_n;
    logic [NLINK-1:0] mask_q;
    logic [RW-1:0]   retry;
    logic [15:0]     wait_cnt;
    logic            win_clear;
    logic            win_enable;
    logic            window_done;
    logic            wait_done;
    logic            pass;
    logic            retry_left;
    logic            last_link;

    assign wait_done  = (wait_cnt == 16'(ALIGN_WAIT - 1));
    assign pass       = (int'(last_errcnt) <= ERR_THRESH);
    assign retry_left = (int'(retry) < MAX_RETRY);
    assign last_link  = (int'(cur_link) == NLINK - 1);

    dtc_win_errchk #(
        .NLINK     (NLINK),
        .TEST_LEN  (TEST_LEN),
        .IDLE_WORD (IDLE_WORD)
    ) u_errchk (
        .bitclkdiv   (bitclkdiv),
        .reset       (reset),
        .clear       (win_clear),
        .enable      (win_enable),
        .sel         (cur_link),
        .data        (deser_dout),
        .count       (last_errcnt),
        .window_done (window_done)
    );

    always_ff @(posedge bitclkdiv) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Start is only looked at in IDLE, which is how a start arriving while
    // a sequence is running gets ignored.
    always_comb begin
        state_n          = state;
        word_align_start = '0;
        busy             = 1'b0;
        done             = 1'b0;
        win_clear        = 1'b0;
        win_enable       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SEL;
                end
            end
            SEL: begin
                busy    = 1'b1;
                state_n = mask_q[cur_link] ? NEXT : ALIGN;
            end
            ALIGN: begin
                busy                       = 1'b1;
                word_align_start[cur_link] = 1'b1;
                state_n                    = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (wait_done) begin
                    win_clear = 1'b1;
                    state_n   = TEST;
                end
            end
            TEST: begin
                busy       = 1'b1;
                win_enable = 1'b1;
                if (window_done) begin
                    state_n = EVAL;
                end
            end
            EVAL: begin
                busy = 1'b1;
                if (pass) begin
                    state_n = NEXT;
                end else if (retry_left) begin
                    state_n = ALIGN;
                end else begin
                    state_n = NEXT;
                end
            end
            NEXT: begin
                busy    = 1'b1;
                state_n = last_link ? DONE : SEL;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Per-link bookkeeping that follows the FSM. cur_link is not cleared
    // on completion so software can see where the last sequence ended.
    always_ff @(posedge bitclkdiv) begin
        if (reset) begin
            mask_q    <= '0;
            cur_link  <= '0;
            link_ok   <= '0;
            link_fail <= '0;
            retry     <= '0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q    <= link_mask;
                        link_ok   <= '0;
                        link_fail <= '0;
                        cur_link  <= '0;
                    end
                end
                SEL: begin
                    if (!mask_q[cur_link]) begin
                        retry <= '0;
                    end
                end
                ALIGN: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
                EVAL: begin
                    if (pass) begin
                        link_ok[cur_link] <= 1'b1;
                    end else if (retry_left) begin
                        retry <= retry + RW'(1);
                    end else begin
                        link_fail[cur_link] <= 1'b1;
                    end
                end
                NEXT: begin
                    if (!last_link) begin
                        cur_link <= cur_link + SW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtc_align_sched.sv
// tb_dtc_align_sched: randomized self-checking bench for dtc_align_sched.
// Each link gets a plan of mismatch counts per alignment attempt; the bench
// injects exactly that many bad words into the comparison window of each
// attempt and predicts pulses, results, error counts and sequence length
// from the sequencing rules.
module tb_dtc_align_sched;

    localparam int          NL     = 4;
    localparam int          AW     = 16;
    localparam int          TL     = 32;
    localparam int          ET     = 2;
    localparam int          MR     = 3;
    localparam logic [15:0] IDLE_W = 16'hBC50;

    logic               bitclkdiv = 1'b0;
    logic               reset;
    logic               start;
    logic [NL-1:0]      link_mask;
    logic [16*NL-1:0]   deser_dout;
    logic [NL-1:0]      word_align_start;
    logic               busy;
    logic               done;
    logic [NL-1:0]      link_ok;
    logic [NL-1:0]      link_fail;
    logic [1:0]         cur_link;
    logic [15:0]        last_errcnt;

    int n_checks = 0;
    int n_fail   = 0;

    int            plan [NL][MR+1];
    int            age [NL];
    int            attempt [NL];
    int            pulses_seen [NL];
    logic [TL-1:0] errpos [NL];
    int            pulse_q [$];
    int            model_last = 0;

    dtc_align_sched #(
        .NLINK      (NL),
        .IDLE_WORD  (IDLE_W),
        .ALIGN_WAIT (AW),
        .TEST_LEN   (TL),
        .ERR_THRESH (ET),
        .MAX_RETRY  (MR)
    ) dut (
        .bitclkdiv        (bitclkdiv),
        .reset            (reset),
        .start            (start),
        .link_mask        (link_mask),
        .deser_dout       (deser_dout),
        .word_align_start (word_align_start),
        .busy             (busy),
        .done             (done),
        .link_ok          (link_ok),
        .link_fail        (link_fail),
        .cur_link         (cur_link),
        .last_errcnt      (last_errcnt)
    );

    always #5 bitclkdiv = ~bitclkdiv;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // k distinct window positions that will carry a bad word
    function automatic logic [TL-1:0] pickPos(input int k);
        logic [TL-1:0] m;
        int n;
        int p;
        m = '0;
        n = 0;
        if (k >= TL) return '1;
        while (n < k) begin
            p = $urandom_range(TL - 1, 0);
            if (!m[p]) begin
                m[p] = 1'b1;
                n++;
            end
        end
        return m;
    endfunction

    task automatic clearTracking();
        for (int i = 0; i < NL; i++) begin
            age[i]         = -1;
            attempt[i]     = 0;
            pulses_seen[i] = 0;
            errpos[i]      = '0;
        end
        pulse_q.delete();
    endtask

    task automatic clearPlan();
        for (int i = 0; i < NL; i++)
            for (int a = 0; a <= MR; a++)
                plan[i][a] = 0;
    endtask

    // Advance one cycle, observe outputs #1 after the edge, then drive the
    // words for the cycle just begun. A pulse seen now is age 0; the words
    // compared in that attempt's window are those of ages AW..AW+TL-1.
    task automatic tick();
        logic [15:0] w;
        @(posedge bitclkdiv);
        #1;
        for (int i = 0; i < NL; i++) begin
            if (age[i] >= 0) age[i]++;
            if (word_align_start[i]) begin
                pulse_q.push_back(i);
                attempt[i] = (pulses_seen[i] > MR) ? MR : pulses_seen[i];
                pulses_seen[i]++;
                age[i]    = 0;
                errpos[i] = pickPos(plan[i][attempt[i]]);
            end
        end
        if (word_align_start != '0)
            checkOutput("align_onehot", $countones(word_align_start), 1);
        for (int i = 0; i < NL; i++) begin
            if (age[i] == AW + TL + 1)
                checkOutput("window_errcnt", last_errcnt, plan[i][attempt[i]]);
        end
        for (int i = 0; i < NL; i++) begin
            w = 16'($urandom);
            if (age[i] >= AW && age[i] < AW + TL) begin
                if (errpos[i][age[i] - AW]) begin
                    w = 16'($urandom);
                    if (w == IDLE_W) w = ~IDLE_W;
                end else begin
                    w = IDLE_W;
                end
            end
            deser_dout[16*i +: 16] = w;
        end
    endtask

    // Run one full sequence with the current plan and check it against
    // the expectations derived from the plan.
    task automatic applyStimulus(input logic [NL-1:0] mask, input bit repulse);
        int            exp_q [$];
        logic [NL-1:0] exp_ok;
        logic [NL-1:0] exp_fail;
        int            exp_done;
        int            rel;
        int            busy_bad;
        int            extra_done;
        int            ncmp;

        exp_ok   = '0;
        exp_fail = '0;
        exp_done = 1;
        for (int i = 0; i < NL; i++) begin
            exp_done += 2;
            if (!mask[i]) begin
                for (int a = 0; a <= MR; a++) begin
                    exp_q.push_back(i);
                    exp_done  += 2 + AW + TL;
                    model_last = plan[i][a];
                    if (plan[i][a] <= ET) begin
                        exp_ok[i] = 1'b1;
                        break;
                    end
                    if (a == MR) exp_fail[i] = 1'b1;
                end
            end
        end

        clearTracking();
        busy_bad = 0;
        start     = 1'b1;
        link_mask = mask;
        tick();
        start     = 1'b0;
        link_mask = NL'($urandom);
        rel = 1;
        while (!done && rel < exp_done + 50) begin
            if (busy !== 1'b1) busy_bad++;
            if (repulse && rel == 7) begin
                start     = 1'b1;
                link_mask = NL'($urandom);
            end
            tick();
            start = 1'b0;
            rel++;
        end
        checkOutput("done_seen", done, 1'b1);
        checkOutput("seq_length", rel, exp_done);
        checkOutput("busy_during", busy_bad, 0);
        checkOutput("busy_at_done", busy, 1'b0);
        checkOutput("link_ok", link_ok, exp_ok);
        checkOutput("link_fail", link_fail, exp_fail);
        checkOutput("ok_fail_excl", link_ok & link_fail, 0);
        checkOutput("cur_link_end", cur_link, NL - 1);
        checkOutput("last_errcnt_end", last_errcnt, model_last);
        checkOutput("pulse_count", pulse_q.size(), exp_q.size());
        ncmp = (pulse_q.size() < exp_q.size()) ? pulse_q.size() : exp_q.size();
        for (int k = 0; k < ncmp; k++)
            checkOutput("pulse_order", pulse_q[k], exp_q[k]);

        extra_done = 0;
        tick();
        checkOutput("done_one_cycle", done, 1'b0);
        checkOutput("busy_after", busy, 1'b0);
        repeat (3) begin
            tick();
            if (done) extra_done++;
        end
        checkOutput("done_once", extra_done, 0);
    endtask

    // Start a clean sequence and pull reset while link 1 is in its window.
    task automatic abortRun();
        int n;
        int late_done;
        clearPlan();
        clearTracking();
        start     = 1'b1;
        link_mask = '0;
        tick();
        start = 1'b0;
        n = 0;
        while (pulses_seen[1] == 0 && n < 500) begin
            tick();
            n++;
        end
        checkOutput("abort_reach_link1", pulses_seen[1], 1);
        repeat (AW + 5) tick();
        checkOutput("abort_ok0_before", link_ok[0], 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort_align", word_align_start, 0);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_done", done, 1'b0);
        checkOutput("abort_ok", link_ok, 0);
        checkOutput("abort_fail", link_fail, 0);
        checkOutput("abort_cur_link", cur_link, 0);
        checkOutput("abort_errcnt", last_errcnt, 0);
        clearTracking();
        late_done = 0;
        repeat (20) begin
            tick();
            if (done || busy) late_done++;
        end
        checkOutput("abort_quiet", late_done, 0);
        model_last = 0;
    endtask

    initial begin
        logic [NL-1:0] rmask;
        int r;
        reset      = 1'b1;
        start      = 1'b0;
        link_mask  = '0;
        deser_dout = '0;
        clearPlan();
        clearTracking();
        repeat (3) tick();
        checkOutput("rst_align", word_align_start, 0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_ok", link_ok, 0);
        checkOutput("rst_fail", link_fail, 0);
        checkOutput("rst_cur_link", cur_link, 0);
        checkOutput("rst_errcnt", last_errcnt, 0);
        // start held together with reset must be dropped
        start = 1'b1;
        tick();
        start = 1'b0;
        reset = 1'b0;
        tick();
        checkOutput("rst_prio_busy", busy, 1'b0);

        $display("[TB] all links clean");
        clearPlan();
        applyStimulus('0, 1'b0);

        $display("[TB] link 2 bad on first attempt");
        clearPlan();
        plan[2][0] = TL;
        applyStimulus('0, 1'b0);

        $display("[TB] link 1 never aligns");
        clearPlan();
        for (int a = 0; a <= MR; a++) plan[1][a] = TL;
        applyStimulus('0, 1'b0);

        $display("[TB] links 0 and 2 masked");
        clearPlan();
        applyStimulus(4'b0101, 1'b0);

        $display("[TB] threshold edge and start while busy");
        clearPlan();
        plan[0][0] = ET;
        plan[3][0] = ET + 1;
        plan[3][1] = ET;
        applyStimulus('0, 1'b1);

        $display("[TB] reset during link 1 window");
        abortRun();
        clearPlan();
        applyStimulus('0, 1'b0);

        $display("[TB] randomized sequences");
        for (int run = 0; run < 16; run++) begin
            for (int i = 0; i < NL; i++) begin
                for (int a = 0; a <= MR; a++) begin
                    r = $urandom_range(3, 0);
                    case (r)
                        0:       plan[i][a] = 0;
                        1:       plan[i][a] = $urandom_range(ET, 1);
                        2:       plan[i][a] = $urandom_range(TL, ET + 1);
                        default: plan[i][a] = TL;
                    endcase
                end
                rmask[i] = ($urandom_range(3, 0) == 0);
            end
            applyStimulus(rmask, run[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
